if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction fetch stage for the RV64I single-issue core; it feeds the decode stage with `inst` and `inst_addr` and handles control transfers on the fetch side.
- Keeps the fetch PC and issues one 32-bit instruction-bus read at a time over a valid/ready request and response-valid protocol.
- Presents each fetched instruction to decode through a registered valid/ready output.
- Takes redirects (resolved branch/jump targets) from downstream and discards stale in-flight responses.

Parameters:
PC_START, 64'h0000_0000_8000_0000, fetch PC after reset.
INST_NOP, 32'h0000_0013, instruction value driven when there is no valid or erroneous fetch (addi x0,x0,0).

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-low (0 = reset).
ibus_req_valid  out  1  fetch request valid.
ibus_req_ready  in  1  bus accepts request.
ibus_req_addr  out  64  request address; equals current pc.
ibus_resp_valid  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
ibus_resp_data  in  32  instruction word.
ibus_resp_err  in  1  bus access fault, qualified by resp_valid.
inst_valid  out  1  output holds an instruction for decode.
id_ready  in  1  decode consumes output this cycle when inst_valid=1.
inst  out  32  instruction to decode.
inst_addr  out  64  PC of inst.
fetch_err  out  1  inst is a fault marker (bus error or misaligned PC).
redirect_valid  in  1  redirect fetch.
redirect_pc  in  64  redirect target.
pc  out  64  current fetch PC (debug/difftest).

Behaviour:
Reset (rst=0 at an edge):
- pc=PC_START, state=REQ, kill=0.
- inst_valid=0, inst=INST_NOP, inst_addr=0, fetch_err=0.
- Reset mid-transaction abandons any outstanding response; the bus is reset together with the core.

States:
- REQ: ibus_req_valid = (!inst_valid | id_ready) & pc[1:0]==0. This guarantees the output slot is free by the time the response returns, so no skid buffer is needed.
- REQ with pc[1:0]!=0: no request; load output with fetch_err=1, inst=INST_NOP, inst_addr=pc, inst_valid=1; go to HALT.
- REQ with req_valid & req_ready: go to WAIT.
- WAIT, resp_valid & kill: drop the response, clear kill, go to REQ.
- WAIT, resp_valid & !kill & !resp_err: inst=resp_data, inst_addr=pc, fetch_err=0, inst_valid=1, pc<=pc+4, go to REQ.
- WAIT, resp_valid & resp_err: inst=INST_NOP, fetch_err=1, inst_addr=pc, inst_valid=1, pc unchanged, go to HALT.
- HALT: no requests; leave only via redirect.
- resp_valid in REQ or HALT without an outstanding request: ignored.

Output register:
- Cleared (inst_valid<=0) when inst_valid & id_ready and no new load occurs that cycle.
- inst, inst_addr and fetch_err hold stable while inst_valid & !id_ready.

Redirect (redirect_valid=1) has priority over every other update:
- pc<=redirect_pc; inst_valid<=0 (flush, regardless of id_ready).
- WAIT without resp_valid: kill<=1, stay in WAIT.
- WAIT with resp_valid: drop the response, go to REQ.
- REQ with a request handshake the same cycle: the old-address request is in flight, so kill<=1, go to WAIT.
- REQ otherwise, or HALT: go to REQ.
- Misaligned redirect_pc is detected in the next REQ cycle.

Arithmetic and throughput:
- pc+4 is modulo 2^64; wrap-around is silent.
- Throughput is at most 1 instruction per 2 cycles (request cycle, then response cycle).
- Minimum latency from request acceptance to inst_valid: 2 edges with a 1-cycle bus.

Decomposition:
defines.v gains:
- `PC_START, `INST_NOP.
- `IF_STATE_BUS [1:0], with encodings IF_REQ=0, IF_WAIT=1, IF_HALT=2.

No sub-module: the FSM, pc register and output register form one flat block of roughly 150-200 lines.

Test Plan:
1. Reset low 3 cycles then high; bus ready=1, resp 1 cycle later with 0x00000013 -> first req_addr 0x80000000; inst_valid with inst_addr 0x80000000; next req_addr 0x80000004.
2. id_ready=0 for 5 cycles after inst_valid -> inst/inst_addr stable, ibus_req_valid=0 throughout; id_ready=1 -> req_addr 0x80000004 issued the same cycle.
3. Redirect to 0x80000100 while in WAIT, old response arrives 2 cycles later -> response dropped, inst_valid stays 0, next req_addr 0x80000100, delivered inst_addr 0x80000100.
4. Redirect to 0x80000200 on the same cycle as a resp_valid, and again on a same-cycle request handshake -> no stale instruction delivered; next delivered inst_addr 0x80000200.
5. Redirect to 0x80000102 -> no bus request; inst_valid=1, fetch_err=1, inst=0x00000013, inst_addr=0x80000102; HALT until redirect to 0x80000000 resumes fetch.
6. resp_err=1 at 0x80000008 -> fetch_err=1, inst_addr=0x80000008, pc stays 0x80000008; with PC_START=64'hFFFF_FFFF_FFFF_FFFC a good fetch -> next req_addr 0x0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset
// defaults and small address helpers.
package if_stage_pkg;

   typedef enum logic [1:0] {
      IF_REQ  = 2'd0,
      IF_WAIT = 2'd1,
      IF_HALT = 2'd2
   } if_state_e;

   localparam logic [63:0] PC_START_DEFAULT = 64'h0000_0000_8000_0000;
   localparam logic [31:0] INST_NOP_DEFAULT = 32'h0000_0013;

   function automatic logic pc_misaligned(input logic [63:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

   function automatic logic [63:0] pc_next_seq(input logic [63:0] addr);
      return addr + 64'd4;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-bus channel: one request (valid/ready) and one response
// (valid only) per transaction.
interface if_stage_if;

   logic        ibus_req_valid;
   logic        ibus_req_ready;
   logic [63:0] ibus_req_addr;
   logic        ibus_resp_valid;
   logic [31:0] ibus_resp_data;
   logic        ibus_resp_err;

   modport master (
      output ibus_req_valid,
      output ibus_req_addr,
      input  ibus_req_ready,
      input  ibus_resp_valid,
      input  ibus_resp_data,
      input  ibus_resp_err
   );

   modport slave (
      input  ibus_req_valid,
      input  ibus_req_addr,
      output ibus_req_ready,
      output ibus_resp_valid,
      output ibus_resp_data,
      output ibus_resp_err
   );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, single-outstanding bus FSM and the
// registered instruction slot presented to decode.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [63:0] PC_START = PC_START_DEFAULT,
   parameter logic [31:0] INST_NOP = INST_NOP_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   if_stage_if.master        ibus,
   output logic              inst_valid,
   input  logic              id_ready,
   output logic [31:0]       inst,
   output logic [63:0]       inst_addr,
   output logic              fetch_err,
   input  logic              redirect_valid,
   input  logic [63:0]       redirect_pc,
   output logic [63:0]       pc
);

   if_state_e   state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic        vld_p0, vld_d;
   logic [31:0] inst_p0, inst_d;
   logic [63:0] inst_addr_p0, inst_addr_d;
   logic        fetch_err_p0, fetch_err_d;

   logic        slot_free;
   logic        misaligned;
   logic        req_fire;

   // Only request when the slot will be free on return, so no skid buffer is needed.
   assign slot_free  = !vld_p0 || id_ready;
   assign misaligned = pc_misaligned(pc_q);
   assign ibus.ibus_req_valid = (state_q == IF_REQ) && slot_free && !misaligned;
   assign ibus.ibus_req_addr  = pc_q;
   assign req_fire   = ibus.ibus_req_valid && ibus.ibus_req_ready;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      vld_d       = vld_p0 && !id_ready;
      inst_d      = inst_p0;
      inst_addr_d = inst_addr_p0;
      fetch_err_d = fetch_err_p0;

      if (redirect_valid) begin
         pc_d    = redirect_pc;
         vld_d   = 1'b0;
         kill_d  = 1'b0;
         state_d = IF_REQ;
         // An old-address request still in flight must be swallowed on return.
         if (state_q == IF_WAIT && !ibus.ibus_resp_valid) begin
            kill_d  = 1'b1;
            state_d = IF_WAIT;
         end else if (state_q == IF_REQ && req_fire) begin
            kill_d  = 1'b1;
            state_d = IF_WAIT;
         end
      end else begin
         case (state_q)
            IF_REQ: begin
               if (misaligned) begin
                  vld_d       = 1'b1;
                  inst_d      = INST_NOP;
                  inst_addr_d = pc_q;
                  fetch_err_d = 1'b1;
                  state_d     = IF_HALT;
               end else if (req_fire) begin
                  state_d = IF_WAIT;
               end
            end
            IF_WAIT: begin
               if (ibus.ibus_resp_valid) begin
                  state_d = IF_REQ;
                  if (kill_q) begin
                     kill_d = 1'b0;
                  end else if (ibus.ibus_resp_err) begin
                     vld_d       = 1'b1;
                     inst_d      = INST_NOP;
                     inst_addr_d = pc_q;
                     fetch_err_d = 1'b1;
                     state_d     = IF_HALT;
                  end else begin
                     vld_d       = 1'b1;
                     inst_d      = ibus.ibus_resp_data;
                     inst_addr_d = pc_q;
                     fetch_err_d = 1'b0;
                     pc_d        = pc_next_seq(pc_q);
                  end
               end
            end
            IF_HALT: begin
               state_d = IF_HALT;
            end
            default: begin
               state_d = IF_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IF_REQ;
         pc_q         <= PC_START;
         kill_q       <= 1'b0;
         vld_p0       <= 1'b0;
         inst_p0      <= INST_NOP;
         inst_addr_p0 <= 64'd0;
         fetch_err_p0 <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_q       <= kill_d;
         vld_p0       <= vld_d;
         inst_p0      <= inst_d;
         inst_addr_p0 <= inst_addr_d;
         fetch_err_p0 <= fetch_err_d;
      end
   end

   assign inst_valid = vld_p0;
   assign inst       = inst_p0;
   assign inst_addr  = inst_addr_p0;
   assign fetch_err  = fetch_err_p0;
   assign pc         = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: transaction-level reference model plus directed and
// randomized bus/decode/redirect stimulus.
module tb_if_stage;
   import if_stage_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        id_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        inst_valid, fetch_err;
   logic [31:0] inst;
   logic [63:0] inst_addr, pc;

   logic        id_ready2 = 1'b0;
   logic        inst_valid2, fetch_err2;
   logic [31:0] inst2;
   logic [63:0] inst_addr2, pc2;

   if_stage_if bus ();
   if_stage_if bus2 ();

   if_stage dut (
      .clk(clk), .rst(rst), .ibus(bus),
      .inst_valid(inst_valid), .id_ready(id_ready), .inst(inst),
      .inst_addr(inst_addr), .fetch_err(fetch_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc)
   );

   if_stage #(.PC_START(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .ibus(bus2),
      .inst_valid(inst_valid2), .id_ready(id_ready2), .inst(inst2),
      .inst_addr(inst_addr2), .fetch_err(fetch_err2),
      .redirect_valid(1'b0), .redirect_pc(64'd0), .pc(pc2)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: what fetch should be doing, in transaction terms.
   logic [63:0] m_pc, m_addr;
   logic [31:0] m_inst;
   bit          m_vld, m_err, m_halt, m_out, m_stale;
   bit          last_rv;
   logic [63:0] last_ra;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 64'h8000_0000; m_vld = 0; m_inst = 32'h13; m_addr = '0;
      m_err = 0; m_halt = 0; m_out = 0; m_stale = 0;
   endtask

   task automatic drive_idle();
      id_ready = 0; redirect_valid = 0; redirect_pc = '0;
      bus.ibus_req_ready = 0; bus.ibus_resp_valid = 0;
      bus.ibus_resp_data = '0; bus.ibus_resp_err = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0;
      drive_idle();
      bus2.ibus_req_ready = 0; bus2.ibus_resp_valid = 0; id_ready2 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 32'h13);
      chk("rst_inst_addr", inst_addr, 0);
      chk("rst_fetch_err", fetch_err, 0);
      chk("rst_pc", pc, 64'h8000_0000);
      rst = 1;
      model_reset();
   endtask

   // One clock: compare against the model, apply inputs, advance the model.
   task automatic cycle(input bit idr, input bit rqr, input bit rv, input logic [31:0] rd,
                        input bit re, input bit rdv, input logic [63:0] rdpc);
      bit exp_req, hs, resp_now;
      @(negedge clk);
      chk("inst_valid", inst_valid, m_vld);
      if (m_vld) begin
         chk("inst", inst, m_inst);
         chk("inst_addr", inst_addr, m_addr);
         chk("fetch_err", fetch_err, m_err);
      end
      chk("pc", pc, m_pc);
      id_ready = idr; bus.ibus_req_ready = rqr; bus.ibus_resp_valid = rv;
      bus.ibus_resp_data = rd; bus.ibus_resp_err = re;
      redirect_valid = rdv; redirect_pc = rdpc;
      #1;
      exp_req = !m_halt && !m_out && (m_pc[1:0] == 2'b00) && (!m_vld || idr);
      chk("req_valid", bus.ibus_req_valid, exp_req);
      if (exp_req) chk("req_addr", bus.ibus_req_addr, m_pc);
      last_rv = bus.ibus_req_valid;
      last_ra = bus.ibus_req_addr;
      @(posedge clk);
      #1;
      hs = exp_req && rqr;
      resp_now = m_out && rv;
      if (rdv) begin
         m_pc = rdpc; m_vld = 0; m_halt = 0;
         if (resp_now) m_out = 0;
         else if (m_out || hs) begin m_out = 1; m_stale = 1; end
         else m_out = 0;
      end else begin
         if (m_vld && idr) m_vld = 0;
         if (!m_halt && !m_out && m_pc[1:0] != 2'b00) begin
            m_vld = 1; m_inst = 32'h13; m_addr = m_pc; m_err = 1; m_halt = 1;
         end else if (hs) begin
            m_out = 1; m_stale = 0;
         end else if (resp_now) begin
            m_out = 0;
            if (!m_stale) begin
               m_vld = 1; m_addr = m_pc; m_err = re;
               if (re) begin m_inst = 32'h13; m_halt = 1; end
               else begin m_inst = rd; m_pc = m_pc + 64'd4; end
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] tgt;
      bit idr, rqr, rv, re, rdv;
      drive_idle();
      bus2.ibus_req_ready = 0; bus2.ibus_resp_valid = 0;
      bus2.ibus_resp_data = '0; bus2.ibus_resp_err = 0;
      model_reset();
      do_reset();

      // Basic fetch after reset
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("t1_req_valid", last_rv, 1);
      chk("t1_req_addr", last_ra, 64'h8000_0000);
      cycle(0, 0, 1, 32'h13, 0, 0, 0);
      chk("t1_inst_valid", inst_valid, 1);
      chk("t1_inst_addr", inst_addr, 64'h8000_0000);
      chk("t1_inst", inst, 32'h13);

      // Decode back-pressure
      repeat (5) begin
         cycle(0, 1, 0, 0, 0, 0, 0);
         chk("t2_no_req", last_rv, 0);
         chk("t2_hold_addr", inst_addr, 64'h8000_0000);
      end
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t2_req_valid", last_rv, 1);
      chk("t2_req_addr", last_ra, 64'h8000_0004);

      // Redirect while waiting; stale response two cycles later
      cycle(0, 0, 0, 0, 0, 1, 64'h8000_0100);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      chk("t3_dropped", inst_valid, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("t3_req_addr", last_ra, 64'h8000_0100);
      cycle(0, 0, 1, 32'h0010_0093, 0, 0, 0);
      chk("t3_inst_addr", inst_addr, 64'h8000_0100);
      chk("t3_inst", inst, 32'h0010_0093);

      // Redirect with same-cycle response, then with same-cycle handshake
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t4_req_addr0", last_ra, 64'h8000_0104);
      cycle(0, 0, 1, 32'hBAD0_BAD0, 0, 1, 64'h8000_0200);
      chk("t4_drop_resp", inst_valid, 0);
      cycle(0, 1, 0, 0, 0, 1, 64'h8000_0200);
      chk("t4_hs_req", last_rv, 1);
      cycle(0, 0, 1, 32'hBAD1_BAD1, 0, 0, 0);
      chk("t4_drop_stale", inst_valid, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("t4_req_addr", last_ra, 64'h8000_0200);
      cycle(0, 0, 1, 32'h0020_0093, 0, 0, 0);
      chk("t4_inst_addr", inst_addr, 64'h8000_0200);
      chk("t4_inst_valid", inst_valid, 1);

      // Misaligned redirect -> fault, halt until redirected
      cycle(1, 0, 0, 0, 0, 1, 64'h8000_0102);
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("t5_no_req", last_rv, 0);
      chk("t5_valid", inst_valid, 1);
      chk("t5_err", fetch_err, 1);
      chk("t5_inst", inst, 32'h13);
      chk("t5_addr", inst_addr, 64'h8000_0102);
      repeat (3) begin
         cycle(1, 1, 0, 0, 0, 0, 0);
         chk("t5_halt_no_req", last_rv, 0);
      end
      cycle(1, 0, 0, 0, 0, 1, 64'h8000_0000);
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t5_resume_req", last_rv, 1);
      chk("t5_resume_addr", last_ra, 64'h8000_0000);

      // Bus error at 0x80000008
      cycle(1, 0, 1, 32'h13, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t6_req4", last_ra, 64'h8000_0004);
      cycle(1, 0, 1, 32'h13, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t6_req8", last_ra, 64'h8000_0008);
      cycle(0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0);
      chk("t6_err", fetch_err, 1);
      chk("t6_addr", inst_addr, 64'h8000_0008);
      chk("t6_inst", inst, 32'h13);
      chk("t6_pc", pc, 64'h8000_0008);
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t6_halt_no_req", last_rv, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         if ($urandom % 600 == 0) do_reset();
         idr = ($urandom % 4) != 0;
         rqr = ($urandom % 3) != 0;
         rv  = m_out ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
         re  = rv && ($urandom % 20 == 0);
         rdv = ($urandom % 10 == 0) || (m_halt && ($urandom % 3 == 0));
         tgt = {32'h0, 32'h8000_0000 + ($urandom % 256) * 4};
         case ($urandom % 8)
            0: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(($urandom % 4) * 4);
            1: tgt = tgt | 64'($urandom_range(1, 3));
            default: ;
         endcase
         cycle(idr, rqr, rv, $urandom, re, rdv, tgt);
      end

      // PC wrap-around on the second instance
      do_reset();
      @(negedge clk);
      bus2.ibus_req_ready = 1;
      #1;
      chk("wrap_req_valid", bus2.ibus_req_valid, 1);
      chk("wrap_req_addr", bus2.ibus_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      @(negedge clk);
      bus2.ibus_req_ready = 0; bus2.ibus_resp_valid = 1; bus2.ibus_resp_data = 32'h13;
      @(negedge clk);
      bus2.ibus_resp_valid = 0;
      chk("wrap_inst_valid", inst_valid2, 1);
      chk("wrap_inst_addr", inst_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_inst", inst2, 32'h13);
      chk("wrap_err", fetch_err2, 0);
      chk("wrap_pc", pc2, 64'h0);
      id_ready2 = 1; bus2.ibus_req_ready = 1;
      #1;
      chk("wrap_next_req", bus2.ibus_req_valid, 1);
      chk("wrap_next_addr", bus2.ibus_req_addr, 64'h0);
      @(negedge clk);
      bus2.ibus_req_ready = 0; id_ready2 = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
